// File: rtl/ece429_pkg.sv
// Shared constants for the ECE429 pipeline: memory window, reset PC and memory port encodings.
package ece429_pkg;

    localparam logic [31:0] MEM_BASE       = 32'h8002_0000;
    localparam int unsigned MEM_SIZE_BYTES = 1048576;
    localparam logic [31:0] RESET_PC       = 32'h8002_0000;
    localparam logic [31:0] MEM_LAST_WORD  = MEM_BASE + 32'(MEM_SIZE_BYTES) - 32'd4;

    localparam logic [1:0] ACCESS_WORD = 2'b11;
    localparam logic [1:0] ACCESS_HALF = 2'b10;
    localparam logic [1:0] ACCESS_BYTE = 2'b00;
    localparam logic       MEM_READ    = 1'b0;
    localparam logic       MEM_WRITE   = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    // A fetch address is legal when word aligned and inside the memory window.
    function automatic logic fetch_addr_ok(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr >= MEM_BASE) && (addr <= MEM_LAST_WORD);
    endfunction

endpackage

// File: rtl/ece429_fetch_queue.sv
// Two-entry {pc, word} FIFO between the fetch memory response and decode; entry 0 is always the head.
module ece429_fetch_queue
    import ece429_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_word,
    input  logic        pop,
    output logic [1:0]  count,
    output logic        head_valid,
    output logic [31:0] head_pc,
    output logic [31:0] head_word
);

    fetch_entry_t entry [2];
    fetch_entry_t push_entry;
    logic         pop_ok;
    logic         push_ok;

    assign push_entry = '{pc: push_pc, word: push_word};
    assign pop_ok     = pop && (count != 2'd0);
    assign push_ok    = push && ((count != 2'd2) || pop_ok);

    // NOTE: the entries are reset because the head is visible on the decode port and must read 0 out of reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= 2'd0;
            entry[0] <= '0;
            entry[1] <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    entry[count[0]] <= push_entry;
                    count           <= count + 2'd1;
                end
                2'b01: begin
                    entry[0] <= entry[1];
                    count    <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry[0] <= push_entry;
                    end else begin
                        entry[0] <= entry[1];
                        entry[1] <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_valid = (count != 2'd0);
    assign head_pc    = entry[0].pc;
    assign head_word  = entry[0].word;

endmodule

// File: rtl/ece429_fetch.sv
// Instruction fetch stage: PC, one word read per cycle, 2-entry queue to decode with redirect flush.
// Optional FETCH_CHECK_EN enables the sticky alignment/range fault on would-be issues.
module ece429_fetch
    import ece429_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        insn_ready,
    output logic        insn_valid,
    output logic [31:0] insn_pc,
    output logic [31:0] insn_word,
    output logic        fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_datain,
    output logic [1:0]  mem_access_size,
    output logic        mem_r_w,
    input  logic [31:0] mem_dataout
);

    logic [31:0] pc;
    logic [31:0] pending_pc;
    logic        pending;
    logic [1:0]  count;
    logic        pop;
    logic        push;
    logic        room;
    logic        want_issue;
    logic        issue;
    logic [31:0] load_pc;

    assign mem_address     = pc;
    assign mem_datain      = 32'd0;
    assign mem_access_size = ACCESS_WORD;
    assign mem_r_w         = MEM_READ;

    assign pop  = insn_valid && insn_ready;
    // Occupancy after this edge, counting the word already in flight, must stay below 2.
    assign room = ({1'b0, count} + {2'b00, pending}) < (3'd2 + {2'b00, pop});
    assign want_issue = !redirect_valid && !fault && room;
    assign push = pending && !redirect_valid;

`ifdef FETCH_CHECK_EN
    logic addr_ok;
    logic fault_q;

    assign addr_ok = fetch_addr_ok(pc);
    assign issue   = want_issue && addr_ok;
    assign load_pc = redirect_pc;
    assign fault   = fault_q;

    // Fault is sticky: only reset clears it, a redirect leaves it standing.
    always_ff @(posedge clock) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (want_issue && !addr_ok) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign issue   = want_issue;
    assign load_pc = redirect_pc & ~32'h3;
    assign fault   = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= RESET_PC;
            pending    <= 1'b0;
            pending_pc <= 32'd0;
        end else if (redirect_valid) begin
            pc      <= load_pc;
            pending <= 1'b0;
        end else if (issue) begin
            pc         <= pc + 32'd4;
            pending    <= 1'b1;
            pending_pc <= pc;
        end else begin
            pending <= 1'b0;
        end
    end

    ece429_fetch_queue u_queue (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_pc    (pending_pc),
        .push_word  (mem_dataout),
        .pop        (pop),
        .count      (count),
        .head_valid (insn_valid),
        .head_pc    (insn_pc),
        .head_word  (insn_word)
    );

endmodule

// File: tb/tb_ece429_fetch.sv
// Directed bench for ece429_fetch with a one-cycle-latency memory model; honours FETCH_CHECK_EN.
module tb_ece429_fetch;

    logic        clock;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        insn_ready;
    logic        insn_valid;
    logic [31:0] insn_pc;
    logic [31:0] insn_word;
    logic        fault;
    logic [31:0] mem_address;
    logic [31:0] mem_datain;
    logic [1:0]  mem_access_size;
    logic        mem_r_w;
    logic [31:0] mem_dataout;

    int n_checks = 0;
    int n_pass   = 0;

    ece429_fetch dut (
        .clock           (clock),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .insn_ready      (insn_ready),
        .insn_valid      (insn_valid),
        .insn_pc         (insn_pc),
        .insn_word       (insn_word),
        .fault           (fault),
        .mem_address     (mem_address),
        .mem_datain      (mem_datain),
        .mem_access_size (mem_access_size),
        .mem_r_w         (mem_r_w),
        .mem_dataout     (mem_dataout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Preloaded words at the window base, elsewhere {addr[15:0], ~addr[15:0]}.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h8002_0000: return 32'h1111_1111;
            32'h8002_0004: return 32'h2222_2222;
            32'h8002_0008: return 32'h3333_3333;
            32'h8002_000C: return 32'h4444_4444;
            default:       return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    always @(posedge clock) mem_dataout <= mem_word(mem_address);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc_exp, input logic [31:0] word_exp);
        check({tag, "_valid"}, {31'd0, insn_valid}, 32'd1);
        check({tag, "_pc"}, insn_pc, pc_exp);
        check({tag, "_word"}, insn_word, word_exp);
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        insn_ready     = 1'b1;
        @(negedge clock);
        step();
        step();

        check("rst_valid", {31'd0, insn_valid}, 32'd0);
        check("rst_pc", insn_pc, 32'd0);
        check("rst_word", insn_word, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_addr", mem_address, 32'h8002_0000);
        check("datain", mem_datain, 32'd0);
        check("access_size", {30'd0, mem_access_size}, 32'd3);
        check("r_w", {31'd0, mem_r_w}, 32'd0);

        // Startup: issue at edge 1, head visible after edge 2, one word per cycle.
        reset = 1'b0;
        step();
        check("e1_valid", {31'd0, insn_valid}, 32'd0);
        check("e1_addr", mem_address, 32'h8002_0004);
        step();
        check_head("e2", 32'h8002_0000, 32'h1111_1111);
        check("e2_addr", mem_address, 32'h8002_0008);
        step();
        check_head("e3", 32'h8002_0004, 32'h2222_2222);
        check("e3_addr", mem_address, 32'h8002_000C);

        // Back-pressure: queue fills, pc parks at 0x8002000C.
        insn_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_head("stall", 32'h8002_0004, 32'h2222_2222);
            check("stall_addr", mem_address, 32'h8002_000C);
        end
        insn_ready = 1'b1;
        step();
        check_head("resume0", 32'h8002_0008, 32'h3333_3333);
        check("resume0_addr", mem_address, 32'h8002_0010);
        step();
        check_head("resume1", 32'h8002_000C, 32'h4444_4444);
        check("resume1_addr", mem_address, 32'h8002_0014);
        step();
        check_head("resume2", 32'h8002_0010, 32'h0010_FFEF);
        check("resume2_addr", mem_address, 32'h8002_0018);

        // Redirect with a queued entry and a read in flight: both are dropped.
        insn_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8002_0100;
        step();
        check("redir_valid", {31'd0, insn_valid}, 32'd0);
        check("redir_addr", mem_address, 32'h8002_0100);
        redirect_valid = 1'b0;
        insn_ready     = 1'b1;
        step();
        check("redir1_valid", {31'd0, insn_valid}, 32'd0);
        check("redir1_addr", mem_address, 32'h8002_0104);
        step();
        check_head("redir2", 32'h8002_0100, 32'h0100_FEFF);
        step();
        check_head("redir3", 32'h8002_0104, 32'h0104_FEFB);

        // Fill the queue, then reset mid-stream.
        insn_ready = 1'b0;
        step();
        check_head("fill", 32'h8002_0104, 32'h0104_FEFB);
        reset = 1'b1;
        step();
        check("midrst_valid", {31'd0, insn_valid}, 32'd0);
        check("midrst_addr", mem_address, 32'h8002_0000);
        check("midrst_fault", {31'd0, fault}, 32'd0);
        check("midrst_pc", insn_pc, 32'd0);
        reset      = 1'b0;
        insn_ready = 1'b1;
        step();
        step();
        check_head("restart", 32'h8002_0000, 32'h1111_1111);

        // Misaligned redirect target.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8002_0102;
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_CHECK_EN
        check("mis_addr", mem_address, 32'h8002_0102);
        check("mis_fault0", {31'd0, fault}, 32'd0);
        step();
        check("mis_fault1", {31'd0, fault}, 32'd1);
        check("mis_valid1", {31'd0, insn_valid}, 32'd0);
        step();
        check("mis_fault2", {31'd0, fault}, 32'd1);
        check("mis_valid2", {31'd0, insn_valid}, 32'd0);
        check("mis_hold", mem_address, 32'h8002_0102);
        // A legal redirect does not clear the fault.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8002_0100;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        check("sticky_fault", {31'd0, fault}, 32'd1);
        check("sticky_valid", {31'd0, insn_valid}, 32'd0);
        check("sticky_addr", mem_address, 32'h8002_0100);
`else
        check("mis_addr", mem_address, 32'h8002_0100);
        step();
        check("mis_valid1", {31'd0, insn_valid}, 32'd0);
        check("mis_addr1", mem_address, 32'h8002_0104);
        step();
        check_head("mis2", 32'h8002_0100, 32'h0100_FEFF);
        check("mis_fault", {31'd0, fault}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
